// File: rtl/music_pkg.sv
// music_pkg: shared constants, types and helpers for the MUSIC DOA covariance stage
package music_pkg;
   localparam int N           = 4;
   localparam int DATA_WIDTH  = 16;
   localparam int ACC_WIDTH   = 32;
   localparam int NUM_ENTRIES = N * (N + 1) / 2;
   typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, OUTPUT, DONE} state_t;
   typedef struct packed {
      logic signed [ACC_WIDTH-1:0] re;
      logic signed [ACC_WIDTH-1:0] im;
   } cplx_t;
   localparam logic [1:0] UT_ROW [NUM_ENTRIES] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
   localparam logic [1:0] UT_COL [NUM_ENTRIES] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};
   localparam logic signed [63:0] SAT_HI = {{(65 - ACC_WIDTH){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
   localparam logic signed [63:0] SAT_LO = ~SAT_HI;
   function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic signed [63:0] x);
      return x > SAT_HI ? ACC_WIDTH'(SAT_HI) : x < SAT_LO ? ACC_WIDTH'(SAT_LO) : ACC_WIDTH'(x);
   endfunction
endpackage

// File: rtl/cov_matrix_accum_if.sv
// cov_matrix_accum_if: sample input and matrix-entry output handshake bundle
interface cov_matrix_accum_if;
   import music_pkg::*;
   logic                          istart;
   logic                          idata_valid;
   logic signed [DATA_WIDTH-1:0]  idata_i0, idata_i1, idata_i2, idata_i3;
   logic signed [DATA_WIDTH-1:0]  idata_q0, idata_q1, idata_q2, idata_q3;
   logic                          oout_valid;
   logic                          iout_ready;
   logic [1:0]                    oout_row, oout_col;
   logic signed [ACC_WIDTH-1:0]   oout_re, oout_im;
   logic                          obusy;
   logic                          odone;
   modport master (
      output istart, idata_valid, idata_i0, idata_i1, idata_i2, idata_i3,
             idata_q0, idata_q1, idata_q2, idata_q3, iout_ready,
      input  oout_valid, oout_row, oout_col, oout_re, oout_im, obusy, odone
   );
   modport slave (
      input  istart, idata_valid, idata_i0, idata_i1, idata_i2, idata_i3,
             idata_q0, idata_q1, idata_q2, idata_q3, iout_ready,
      output oout_valid, oout_row, oout_col, oout_re, oout_im, obusy, odone
   );
endinterface

// File: rtl/cov_cmac.sv
// cov_cmac: pipelined conjugate complex multiply-accumulate of x_m * conj(x_n)
module cov_cmac
   import music_pkg::*;
#(
   parameter int AW   = 42,
   parameter bit DIAG = 1'b0
) (
   input  logic                         iclk,
   input  logic                         irst_n,
   input  logic                         clr,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] a_q,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   input  logic signed [DATA_WIDTH-1:0] b_q,
   output logic signed [AW-1:0]         acc_re,
   output logic signed [AW-1:0]         acc_im
);
   localparam int PW = 2 * DATA_WIDTH + 1;
   logic signed [PW-1:0] re_n, im_n, p_re, p_im;
   logic p_v;
   assign re_n = PW'(a_i) * PW'(b_i) + PW'(a_q) * PW'(b_q);
   if (DIAG) begin : g_diag
      assign im_n = '0;
   end else begin : g_off
      assign im_n = PW'(a_q) * PW'(b_i) - PW'(a_i) * PW'(b_q);
   end
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         p_v    <= 1'b0;
         p_re   <= '0;
         p_im   <= '0;
         acc_re <= '0;
         acc_im <= '0;
      end else begin
         p_v  <= in_valid && !clr;
         p_re <= re_n;
         p_im <= im_n;
         if (clr) begin
            acc_re <= '0;
            acc_im <= '0;
         end else if (p_v) begin
            acc_re <= acc_re + AW'(p_re);
            acc_im <= acc_im + AW'(p_im);
         end
      end
   end
endmodule

// File: rtl/cov_matrix_accum.sv
// cov_matrix_accum: frame-based 4x4 sample covariance estimator streaming the upper triangle
module cov_matrix_accum
   import music_pkg::*;
#(
   parameter int SAMPLES_NUM = 512
) (
   input  logic              iclk,
   input  logic              irst_n,
   cov_matrix_accum_if.slave bus
);
   localparam int SH = $clog2(SAMPLES_NUM);
   localparam int AW = 2 * DATA_WIDTH + 1 + SH;
   state_t state;
   logic [SH-1:0] cnt;
   logic [1:0] fc;
   logic [3:0] idx, ld_idx;
   logic capture, clr, s_v, load;
   logic signed [DATA_WIDTH-1:0] s_i [N];
   logic signed [DATA_WIDTH-1:0] s_q [N];
   logic signed [AW-1:0] acc_re [NUM_ENTRIES];
   logic signed [AW-1:0] acc_im [NUM_ENTRIES];
   cplx_t ent;
   assign capture = state == ACCUM && bus.idata_valid;
   assign clr     = state == IDLE && bus.istart;
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         s_v <= 1'b0;
         s_i <= '{default: '0};
         s_q <= '{default: '0};
      end else begin
         s_v <= capture;
         if (capture) begin
            s_i <= '{bus.idata_i0, bus.idata_i1, bus.idata_i2, bus.idata_i3};
            s_q <= '{bus.idata_q0, bus.idata_q1, bus.idata_q2, bus.idata_q3};
         end
      end
   end
   for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_pair
      cov_cmac #(.AW(AW), .DIAG(UT_ROW[k] == UT_COL[k])) u_cmac (
         .iclk     (iclk),
         .irst_n   (irst_n),
         .clr      (clr),
         .in_valid (s_v),
         .a_i      (s_i[UT_ROW[k]]),
         .a_q      (s_q[UT_ROW[k]]),
         .b_i      (s_i[UT_COL[k]]),
         .b_q      (s_q[UT_COL[k]]),
         .acc_re   (acc_re[k]),
         .acc_im   (acc_im[k])
      );
   end
   // entry presented next: the first after FLUSH, otherwise the successor of the current one
   always_comb begin
      ld_idx = state == OUTPUT ? idx + 4'd1 : 4'd0;
      load   = (state == FLUSH && fc == 2'd3) ||
               (state == OUTPUT && bus.iout_ready && idx != 4'(NUM_ENTRIES - 1));
      ent.re = saturate(64'(acc_re[ld_idx] >>> SH));
      ent.im = saturate(64'(acc_im[ld_idx] >>> SH));
   end
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         fc             <= '0;
         idx            <= '0;
         bus.oout_valid <= 1'b0;
         bus.oout_row   <= '0;
         bus.oout_col   <= '0;
         bus.oout_re    <= '0;
         bus.oout_im    <= '0;
         bus.obusy      <= 1'b0;
         bus.odone      <= 1'b0;
      end else begin
         bus.odone <= 1'b0;
         case (state)
            IDLE: if (bus.istart) begin
               state     <= ACCUM;
               cnt       <= '0;
               bus.obusy <= 1'b1;
            end
            ACCUM: if (capture) begin
               cnt <= cnt + 1'b1;
               fc  <= '0;
               if (cnt == '1) state <= FLUSH;
            end
            FLUSH: begin
               fc <= fc + 1'b1;
               if (fc == 2'd3) state <= OUTPUT;
            end
            OUTPUT: if (bus.iout_ready && idx == 4'(NUM_ENTRIES - 1)) begin
               state          <= DONE;
               bus.oout_valid <= 1'b0;
               bus.odone      <= 1'b1;
               bus.obusy      <= 1'b0;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
         if (load) begin
            idx            <= ld_idx;
            bus.oout_valid <= 1'b1;
            bus.oout_row   <= UT_ROW[ld_idx];
            bus.oout_col   <= UT_COL[ld_idx];
            bus.oout_re    <= ent.re;
            bus.oout_im    <= ent.im;
         end
      end
   end
endmodule

// File: tb/tb_cov_matrix_accum.sv
// tb_cov_matrix_accum: randomized self-checking bench against a behavioural covariance model
module tb_cov_matrix_accum;
   localparam int K = 512;
   localparam int SH = 9;
   localparam longint LIM = 64'sd2147483647;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int pass_n = 0;
   int total_n = 0;
   int tr [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
   int tc [10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
   int xi [4];
   int xq [4];
   longint s_re [10];
   longint s_im [10];
   int g_row [$];
   int g_col [$];
   longint g_re [$];
   longint g_im [$];
   int lat, span, hs, hs0, hs_n;
   bit stable_ok;
   logic d_done, d_busy, d_valid, d2_done, d2_busy;

   always #5 clk = ~clk;

   cov_matrix_accum_if bus();
   cov_matrix_accum #(.SAMPLES_NUM(K)) dut (.iclk(clk), .irst_n(rst_n), .bus(bus));

   initial hs = 0;
   always @(posedge clk) if (bus.oout_valid && bus.iout_ready) hs <= hs + 1;

   function automatic longint expv(input longint s);
      longint v = s >>> SH;
      return v > LIM ? LIM : (v < -LIM - 1 ? -LIM - 1 : v);
   endfunction

   task automatic set_sample(input int kind);
      for (int c = 0; c < 4; c++) begin
         case (kind)
            0: begin xi[c] = 1000; xq[c] = 0; end
            1: begin xi[c] = c == 0 ? 1000 : 0; xq[c] = c == 1 ? 1000 : 0; end
            2: begin xi[c] = -32768; xq[c] = -32768; end
            default: begin
               xi[c] = int'($urandom_range(0, 65535)) - 32768;
               xq[c] = int'($urandom_range(0, 65535)) - 32768;
            end
         endcase
      end
      bus.idata_i0 = 16'(xi[0]); bus.idata_i1 = 16'(xi[1]);
      bus.idata_i2 = 16'(xi[2]); bus.idata_i3 = 16'(xi[3]);
      bus.idata_q0 = 16'(xq[0]); bus.idata_q1 = 16'(xq[1]);
      bus.idata_q2 = 16'(xq[2]); bus.idata_q3 = 16'(xq[3]);
   endtask

   // R(m,n) accumulates x_m * conj(x_n) over every snapshot the DUT is expected to capture
   task automatic model_add();
      for (int k = 0; k < 10; k++) begin
         s_re[k] += longint'(xi[tr[k]]) * xi[tc[k]] + longint'(xq[tr[k]]) * xq[tc[k]];
         s_im[k] += longint'(xq[tr[k]]) * xi[tc[k]] - longint'(xi[tr[k]]) * xq[tc[k]];
      end
   endtask

   task automatic run_frame(input int kind, input bit toggle, input int stall_idx, input int n_samp,
                            input bit start_in_done);
      int got = 0;
      int cyc = 0;
      int stall = 0;
      bit pv = 0, pr = 0, rdy;
      logic [1:0] prow, pcol;
      logic signed [31:0] pre, pim;
      for (int k = 0; k < 10; k++) begin s_re[k] = 0; s_im[k] = 0; end
      g_row.delete(); g_col.delete(); g_re.delete(); g_im.delete();
      lat = -1; span = 0; stable_ok = 1; hs0 = hs;
      bus.iout_ready = 1'b1;
      @(negedge clk);
      set_sample(3); bus.idata_valid = 1'b1; bus.istart = 1'b1;
      @(negedge clk);
      bus.istart = 1'b0;
      while (got < n_samp) begin
         if (toggle && cyc % 2 == 1) begin
            set_sample(3); bus.idata_valid = 1'b0;
         end else begin
            set_sample(kind); bus.idata_valid = 1'b1; model_add(); got++;
         end
         cyc++;
         @(negedge clk);
      end
      if (n_samp < K) begin
         rst_n = 1'b0; bus.idata_valid = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      set_sample(3); bus.idata_valid = 1'b1;
      lat = 0;
      while (!bus.oout_valid && lat < 20) begin @(negedge clk); lat++; end
      while (g_row.size() < 10 && span < 100) begin
         if (pv && !pr && (!bus.oout_valid || bus.oout_row !== prow || bus.oout_col !== pcol ||
             bus.oout_re !== pre || bus.oout_im !== pim)) stable_ok = 0;
         rdy = !(bus.oout_valid && g_row.size() == stall_idx && stall < 5);
         if (!rdy) stall++;
         bus.iout_ready = rdy;
         if (bus.oout_valid && rdy) begin
            g_row.push_back(int'(bus.oout_row)); g_col.push_back(int'(bus.oout_col));
            g_re.push_back(longint'(bus.oout_re)); g_im.push_back(longint'(bus.oout_im));
         end
         pv = bus.oout_valid; pr = rdy;
         prow = bus.oout_row; pcol = bus.oout_col; pre = bus.oout_re; pim = bus.oout_im;
         @(negedge clk);
         span++;
      end
      d_done = bus.odone; d_busy = bus.obusy; d_valid = bus.oout_valid;
      if (start_in_done) bus.istart = 1'b1;
      @(negedge clk);
      bus.istart = 1'b0; bus.idata_valid = 1'b0;
      d2_done = bus.odone; d2_busy = bus.obusy;
      hs_n = hs - hs0;
   endtask

   task automatic test_reset();
      bus.istart = 1'b0; bus.idata_valid = 1'b0; bus.iout_ready = 1'b1;
      set_sample(3);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total_n++;
      if ({bus.oout_valid, bus.obusy, bus.odone} !== 3'b000)
         $display("FAIL reset_ctrl: got valid/busy/done=%b expected 000", {bus.oout_valid, bus.obusy, bus.odone});
      else pass_n++;
      total_n++;
      if ({bus.oout_row, bus.oout_col, bus.oout_re, bus.oout_im} !== 68'd0)
         $display("FAIL reset_data: got row=%0d col=%0d re=%0d im=%0d expected zeros",
                  bus.oout_row, bus.oout_col, bus.oout_re, bus.oout_im);
      else pass_n++;
      rst_n = 1'b1;
      bus.idata_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.idata_valid = 1'b0;
      total_n++;
      if (bus.obusy !== 1'b0 || bus.oout_valid !== 1'b0)
         $display("FAIL idle_ignore: got busy=%b valid=%b expected 0 0", bus.obusy, bus.oout_valid);
      else pass_n++;
   endtask

   task automatic test_constant();
      run_frame(0, 0, -1, K, 0);
      total_n++;
      if (g_row.size() != 10) $display("FAIL const_count: got %0d expected 10", g_row.size()); else pass_n++;
      for (int k = 0; k < 10; k++) begin
         total_n++;
         if (g_row[k] !== tr[k] || g_col[k] !== tc[k] || g_re[k] !== 64'sd1000000 || g_im[k] !== 64'sd0)
            $display("FAIL const_entry%0d: got (%0d,%0d) re=%0d im=%0d expected (%0d,%0d) re=1000000 im=0",
                     k, g_row[k], g_col[k], g_re[k], g_im[k], tr[k], tc[k]);
         else pass_n++;
      end
      total_n++;
      if (lat !== 4) $display("FAIL const_latency: got %0d expected 4", lat); else pass_n++;
      total_n++;
      if (span !== 10) $display("FAIL const_b2b_cycles: got %0d expected 10", span); else pass_n++;
      total_n++;
      if ({d_done, d_busy, d_valid} !== 3'b100)
         $display("FAIL const_done: got done/busy/valid=%b expected 100", {d_done, d_busy, d_valid});
      else pass_n++;
      total_n++;
      if (d2_done !== 1'b0) $display("FAIL const_done_pulse: got %b expected 0", d2_done); else pass_n++;
      total_n++;
      if (hs_n !== 10) $display("FAIL const_handshakes: got %0d expected 10", hs_n); else pass_n++;
   endtask

   task automatic test_orthogonal();
      run_frame(1, 0, -1, K, 0);
      for (int k = 0; k < 10; k++) begin
         total_n++;
         if (g_row[k] !== tr[k] || g_col[k] !== tc[k] || g_re[k] !== expv(s_re[k]) || g_im[k] !== expv(s_im[k]))
            $display("FAIL ortho_entry%0d: got re=%0d im=%0d expected re=%0d im=%0d",
                     k, g_re[k], g_im[k], expv(s_re[k]), expv(s_im[k]));
         else pass_n++;
      end
      total_n++;
      if (g_im[1] !== -64'sd1000000) $display("FAIL ortho_im01: got %0d expected -1000000", g_im[1]); else pass_n++;
   endtask

   task automatic test_saturate();
      run_frame(2, 0, -1, K, 0);
      for (int k = 0; k < 10; k++) begin
         total_n++;
         if (g_re[k] !== LIM || g_im[k] !== 64'sd0 || g_re[k] !== expv(s_re[k]))
            $display("FAIL sat_entry%0d: got re=%0d im=%0d expected re=%0d im=0", k, g_re[k], g_im[k], LIM);
         else pass_n++;
      end
   endtask

   task automatic test_toggle();
      run_frame(0, 1, -1, K, 0);
      for (int k = 0; k < 10; k++) begin
         total_n++;
         if (g_row[k] !== tr[k] || g_col[k] !== tc[k] || g_re[k] !== 64'sd1000000 || g_im[k] !== 64'sd0)
            $display("FAIL toggle_entry%0d: got (%0d,%0d) re=%0d im=%0d expected re=1000000 im=0",
                     k, g_row[k], g_col[k], g_re[k], g_im[k]);
         else pass_n++;
      end
      total_n++;
      if (lat !== 4) $display("FAIL toggle_latency: got %0d expected 4", lat); else pass_n++;
   endtask

   task automatic test_stall();
      run_frame(3, 0, 2, K, 0);
      total_n++;
      if (!stable_ok) $display("FAIL stall_stable: got unstable entry expected held values"); else pass_n++;
      total_n++;
      if (hs_n !== 10) $display("FAIL stall_handshakes: got %0d expected 10", hs_n); else pass_n++;
      total_n++;
      if (span !== 15) $display("FAIL stall_cycles: got %0d expected 15", span); else pass_n++;
      for (int k = 0; k < 10; k++) begin
         total_n++;
         if (g_row[k] !== tr[k] || g_col[k] !== tc[k] || g_re[k] !== expv(s_re[k]) || g_im[k] !== expv(s_im[k]))
            $display("FAIL stall_entry%0d: got (%0d,%0d) re=%0d im=%0d expected (%0d,%0d) re=%0d im=%0d",
                     k, g_row[k], g_col[k], g_re[k], g_im[k], tr[k], tc[k], expv(s_re[k]), expv(s_im[k]));
         else pass_n++;
      end
   endtask

   task automatic test_abort();
      int seen = 0;
      run_frame(0, 0, -1, 300, 0);
      total_n++;
      if ({bus.oout_valid, bus.obusy, bus.odone} !== 3'b000)
         $display("FAIL abort_reset: got valid/busy/done=%b expected 000", {bus.oout_valid, bus.obusy, bus.odone});
      else pass_n++;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.oout_valid || bus.obusy) seen++;
      end
      total_n++;
      if (seen !== 0) $display("FAIL abort_stale: got %0d active cycles expected 0", seen); else pass_n++;
      run_frame(0, 0, -1, K, 0);
      total_n++;
      if (hs_n !== 10) $display("FAIL abort_handshakes: got %0d expected 10", hs_n); else pass_n++;
      for (int k = 0; k < 10; k++) begin
         total_n++;
         if (g_row[k] !== tr[k] || g_col[k] !== tc[k] || g_re[k] !== 64'sd1000000 || g_im[k] !== 64'sd0)
            $display("FAIL abort_entry%0d: got (%0d,%0d) re=%0d im=%0d expected re=1000000 im=0",
                     k, g_row[k], g_col[k], g_re[k], g_im[k]);
         else pass_n++;
      end
   endtask

   task automatic test_back_to_back();
      run_frame(3, 0, -1, K, 1);
      total_n++;
      if (d2_busy !== 1'b0) $display("FAIL start_in_done: got busy=%b expected 0", d2_busy); else pass_n++;
      for (int f = 0; f < 2; f++) begin
         if (f == 1) run_frame(3, 0, -1, K, 0);
         for (int k = 0; k < 10; k++) begin
            total_n++;
            if (g_re[k] !== expv(s_re[k]) || g_im[k] !== expv(s_im[k]))
               $display("FAIL b2b_f%0d_entry%0d: got re=%0d im=%0d expected re=%0d im=%0d",
                        f, k, g_re[k], g_im[k], expv(s_re[k]), expv(s_im[k]));
            else pass_n++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_orthogonal();
      test_saturate();
      test_toggle();
      test_stall();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
